// File: rtl/team_06_pkg.sv
// Shared register map, bit positions and event record for the team_06 GPIO event queue.
package team_06_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_EVENT  = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_CLR    = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_IRQ_BIT  = 1;
  localparam int CLR_OVF_BIT   = 0;
  localparam int CLR_FLUSH_BIT = 1;
  localparam int ST_EMPTY_BIT  = 8;
  localparam int ST_FULL_BIT   = 9;
  localparam int ST_OVF_BIT    = 10;

  typedef struct packed {
    logic [15:0] ts;
    logic        rise;
    logic [3:0]  pin;
  } event_t;

  function automatic logic [31:0] pack_event(input event_t e);
    return {e.ts, 7'b0, e.rise, 4'b0, e.pin};
  endfunction

endpackage

// File: rtl/team_06_debounce.sv
// Per-pin two-flop synchronizer plus debounce timer; change pulses on the cycle level flips.
module team_06_debounce #(
  parameter int DB_CYCLES = 1000
) (
  input  logic clk_i,
  input  logic nrst,
  input  logic raw,
  output logic level,
  output logic change
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DB_CYCLES - 1);

  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;

  // Down-counter reloads whenever the input agrees with the accepted level.
  assign change = (sync != level) && (cnt == '0);

  always_ff @(posedge clk_i or negedge nrst) begin
    if (!nrst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      cnt   <= RELOAD;
    end else begin
      meta <= raw;
      sync <= meta;
      if (sync == level) begin
        cnt <= RELOAD;
      end else if (cnt == '0) begin
        level <= sync;
        cnt   <= RELOAD;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/team_06_gpio_event_queue.sv
// Debounced GPIO edge events queued in a FIFO behind a Wishbone slave.
// Define TEAM_06_TIMESTAMP_EN to stamp each event with a free-running 16-bit counter.
module team_06_gpio_event_queue
  import team_06_pkg::*;
#(
  parameter int NUM_IN     = 8,
  parameter int DB_CYCLES  = 1000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              nrst,
  input  logic [NUM_IN-1:0] gpio_in,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [3:0]        adr_i,
  input  logic [31:0]       dat_i,
  input  logic [3:0]        sel_i,
  output logic [31:0]       dat_o,
  output logic              ack_o,
  output logic              irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [NUM_IN-1:0] level, change, pending, pend_edge, arb_mask;
  logic              arb_valid, arb_rise;
  logic [3:0]        arb_pin;
  logic              ctrl_en, ctrl_irq_en, overflow;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  event_t            mem [FIFO_DEPTH];
  event_t            head;
  logic [15:0]       ts_now;
  logic [31:0]       rd_data;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_db
    team_06_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk_i  (clk_i),
      .nrst   (nrst),
      .raw    (gpio_in[g]),
      .level  (level[g]),
      .change (change[g])
    );
  end

`ifdef TEAM_06_TIMESTAMP_EN
  logic [15:0] ts_cnt;
  always_ff @(posedge clk_i or negedge nrst) begin
    if (!nrst) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 16'd1;
  end
  assign ts_now = ts_cnt;
`else
  assign ts_now = '0;
`endif

  // Lowest index wins; the loop runs high-to-low so the last hit is the lowest pin.
  always_comb begin
    arb_valid = 1'b0;
    arb_pin   = '0;
    arb_rise  = 1'b0;
    arb_mask  = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (pending[i]) begin
        arb_valid   = 1'b1;
        arb_pin     = 4'(i);
        arb_rise    = pend_edge[i];
        arb_mask    = '0;
        arb_mask[i] = 1'b1;
      end
    end
  end

  logic       req, wr, rd, empty, full, pop, flush, ovf_clr, push_req, do_push, drop;
  logic [1:0] reg_sel;

  assign req      = cyc_i & stb_i & ~ack_o;
  assign wr       = req & we_i;
  assign rd       = req & ~we_i;
  assign reg_sel  = adr_i[3:2];
  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = rd & (reg_sel == REG_EVENT) & ~empty;
  assign flush    = wr & (reg_sel == REG_CLR) & dat_i[CLR_FLUSH_BIT];
  assign ovf_clr  = wr & (reg_sel == REG_CLR) & dat_i[CLR_OVF_BIT];
  assign push_req = arb_valid & ctrl_en;
  assign do_push  = push_req & ~flush & (~full | pop);
  assign drop     = push_req & ~flush & full & ~pop;
  assign head     = mem[rd_ptr];

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_STATUS: begin
        rd_data[4:0]         = 5'(count);
        rd_data[ST_EMPTY_BIT] = empty;
        rd_data[ST_FULL_BIT]  = full;
        rd_data[ST_OVF_BIT]   = overflow;
      end
      REG_EVENT: rd_data = empty ? 32'h0 : pack_event(head);
      REG_CTRL: begin
        rd_data[CTRL_EN_BIT]  = ctrl_en;
        rd_data[CTRL_IRQ_BIT] = ctrl_irq_en;
      end
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= '{ts: ts_now, rise: arb_rise, pin: arb_pin};
  end

  always_ff @(posedge clk_i or negedge nrst) begin
    if (!nrst) begin
      ack_o       <= 1'b0;
      dat_o       <= '0;
      irq_o       <= 1'b0;
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      pending     <= '0;
      pend_edge   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
    end else begin
      ack_o <= req;
      dat_o <= rd ? rd_data : 32'h0;
      if (wr && (reg_sel == REG_CTRL) && sel_i[0]) begin
        ctrl_en     <= dat_i[CTRL_EN_BIT];
        ctrl_irq_en <= dat_i[CTRL_IRQ_BIT];
      end
      pending   <= (pending & ~(push_req ? arb_mask : '0)) | (change & {NUM_IN{ctrl_en}});
      pend_edge <= (pend_edge & ~change) | (~level & change);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(do_push) - CW'(pop);
      end
      if (ovf_clr) overflow <= 1'b0;
      if (drop)    overflow <= 1'b1;
      irq_o <= ctrl_irq_en & (~empty | overflow);
    end
  end

  logic unused_bits;
  assign unused_bits = ^{sel_i[3:1], adr_i[1:0], dat_i[31:2]};

endmodule

// File: doc/team_06_gpio_event_queue.md
# team_06_gpio_event_queue

Wishbone-slave input stage for the team_06 design. It sits behind the team's bus wrapper on the user-area GPIO inputs and turns raw button and switch pins into debounced edge events. Each event is queued in a small FIFO and read out by the management core over Wishbone. An interrupt is raised while events are pending or an overflow has occurred.

## Interface
- NUM_IN, 8: number of GPIO inputs monitored (1..16).
- DB_CYCLES, 1000: consecutive stable cycles needed to accept a new level; must be ≥ NUM_IN.
- FIFO_DEPTH, 8: event queue depth; power of two, 2..16.
- clk_i  in  1  system clock (wb_clk_i domain).
- nrst  in  1  asynchronous active-low reset.
- gpio_in  in  NUM_IN  raw asynchronous pin levels.
- cyc_i, stb_i, we_i  in  1 each  Wishbone cycle, strobe and write enable.
- adr_i  in  4  byte address; bits [1:0] are ignored.
- dat_i  in  32  write data.
- sel_i  in  4  byte selects; only byte 0 is honoured for CTRL.
- dat_o  out  32  read data.
- ack_o  out  1  single-cycle acknowledge.
- irq_o  out  1  level interrupt.

## Operation
- Synchronizer:
  - Two flops per pin; the second flop is the "sync" level.
- Debounce, per pin:
  - A counter counts cycles while sync ≠ stable and clears whenever sync = stable.
  - When the counter reaches DB_CYCLES−1, stable ← sync and the counter clears.
  - A stable change sets pending[i] and pend_edge[i] (1 = rising).
- Arbiter:
  - Each cycle, the lowest-index pending pin with CTRL.enable=1 is pushed and its pending bit cleared.
  - When CTRL.enable=0, changes still update stable, but pending is not set.
- Event word:
  - [3:0] pin index.
  - [8] edge.
  - [31:16] timestamp (see Configuration).
  - All other bits are 0.
- FIFO push while full:
  - The event is dropped and overflow is set (sticky).
  - A simultaneous pop while full frees a slot, so the push succeeds.
- Registers (word offset):
  - 0x0 STATUS (RO): [4:0] count, [8] empty, [9] full, [10] overflow.
  - 0x4 EVENT (RO): reading pops the head and returns it. A read when empty returns 0 and does not pop.
  - 0x8 CTRL (RW): [0] enable, [1] irq_en.
  - 0xC CLR (WO): writing 1 to bit 0 clears overflow; writing 1 to bit 1 flushes the FIFO.
  - Writes to RO addresses and reads from WO addresses complete with ack; reads return 0.
- Interrupt: irq_o = irq_en & (!empty | overflow), registered.

## Timing
- Reset values:
  - dat_o=0, ack_o=0, irq_o=0, CTRL=0.
  - stable=0, pending=0, FIFO empty, overflow=0, timestamp=0.
- Wishbone:
  - A request is cyc_i&stb_i&!ack_o.
  - ack_o and dat_o are registered one cycle after the request.
  - ack_o is high for exactly one cycle.
  - Back-to-back requests are therefore acked every other cycle.
- Write and pop timing:
  - Register writes and the EVENT pop take effect on the ack cycle edge.
  - A new head is readable on the next request.
- Pin-to-FIFO latency: 2 (sync) + DB_CYCLES + 1 (arbiter) cycles from a pin change to the count incrementing.
- irq_o lags the FIFO/overflow state by 1 cycle.
- Flush and push on the same cycle: the flush wins and the event is discarded. Overflow is not set.
- Reset asserted mid-transaction: all state clears immediately; any pending ack is lost.

## Configuration
- TEAM_06_TIMESTAMP_EN defined:
  - A 16-bit free-running counter (wraps 0xFFFF→0) is built.
  - Its value at push time is stored in event [31:16].
- TEAM_06_TIMESTAMP_EN undefined:
  - No counter is built; [31:16] reads 0.

## Structure
- team_06_pkg holds:
  - Register offset localparams (REG_STATUS, REG_EVENT, REG_CTRL, REG_CLR).
  - Bit-position constants.
  - The packed typedef event_t {ts[15:0], edge, pin[3:0]}.
- One sub-module, team_06_debounce: per-pin synchronizer, counter and stable/change output, instantiated NUM_IN times in a generate loop.
- The FIFO and arbiter are inline in team_06_gpio_event_queue.

## Test plan
- Reset, then read STATUS → 0x0000_0100 (empty); read EVENT → 0; irq_o=0.
- DB_CYCLES=4, CTRL=0x3, pin 2 pulsed high for 3 cycles → no event. Held for 8 cycles → count=1; EVENT = 0x102 plus timestamp; irq_o goes 1, then 0 after the pop.
- Pins 0 and 5 rise on the same cycle → two events in order pin 0, then pin 5, on consecutive cycles.
- FIFO_DEPTH=8, 9 edges with no reads → STATUS full=1, overflow=1, count=8. Write CLR=1 → overflow=0; irq_o stays 1 until the FIFO is empty.
- CTRL.enable=0, pin 1 toggles → count stays 0. Set enable, read STATUS → still 0.
- With TEAM_06_TIMESTAMP_EN, two events 100 cycles apart → timestamp difference = 100. Without the macro → [31:16]=0.
